// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan display: BCD digit width and
// active-low segment patterns ordered {A,B,C,D,E,F,G}.
package seg7_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Codes 10..15 cannot come out of a valid conversion; show them blank.
  function automatic logic [6:0] seg_encode(input logic [BCD_W-1:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one bit per cycle.
// done and bcd are combinational on the final step so the caller can capture the result on that edge.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int VALUE_W    = 27,
  parameter int BCD_DIGITS = (VALUE_W + 2) / 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [VALUE_W-1:0]            value,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGITS*BCD_W-1:0]   bcd
);

  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;

  logic [VALUE_W-1:0]          bin_p0;
  logic [BCD_DIGITS*BCD_W-1:0] bcd_p0;
  logic [BCD_DIGITS*BCD_W-1:0] bcd_adj;
  logic [BCD_DIGITS*BCD_W-1:0] bcd_step;
  logic [CNT_W-1:0]            cnt_p0;
  logic                        busy_p0;

  always_comb begin
    bcd_adj = bcd_p0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_adj[i*BCD_W +: BCD_W] >= 4'd5)
        bcd_adj[i*BCD_W +: BCD_W] = bcd_adj[i*BCD_W +: BCD_W] + 4'd3;
    end
    bcd_step = {bcd_adj[BCD_DIGITS*BCD_W-2:0], bin_p0[VALUE_W-1]};
  end

  assign busy = busy_p0;
  assign done = busy_p0 && (cnt_p0 == CNT_W'(VALUE_W - 1));
  assign bcd  = bcd_step;

  // stage p0: control
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_p0 <= 1'b0;
      cnt_p0  <= '0;
    end else if (start && !busy_p0) begin
      busy_p0 <= 1'b1;
      cnt_p0  <= '0;
    end else if (busy_p0) begin
      cnt_p0 <= cnt_p0 + 1'b1;
      if (done)
        busy_p0 <= 1'b0;
    end
  end

  // stage p0: shift datapath
  always_ff @(posedge clk) begin
    if (start && !busy_p0) begin
      bin_p0 <= value;
      bcd_p0 <= '0;
    end else if (busy_p0) begin
      bin_p0 <= bin_p0 << 1;
      bcd_p0 <= bcd_step;
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment display: converts a binary value to BCD, then scans
// the digits with leading-zero blanking, overflow dashes, decimal points and blink.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int VALUE_W     = 27,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  blink_en,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  A,
  output logic                  B,
  output logic                  C,
  output logic                  D,
  output logic                  E,
  output logic                  F,
  output logic                  G,
  output logic                  dp
);

  localparam int BCD_DIGITS = (VALUE_W + 2) / 3;
  localparam int WIDE_D     = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W      = $clog2(REFRESH_DIV);
  localparam int BLK_W      = $clog2(BLINK_DIV);

  logic                          conv_busy;
  logic                          conv_done;
  logic [BCD_DIGITS*BCD_W-1:0]   conv_bcd;
  logic [WIDE_D*BCD_W-1:0]       bcd_wide;
  logic                          conv_ovf;

  bin2bcd_seq #(
    .VALUE_W    (VALUE_W),
    .BCD_DIGITS (BCD_DIGITS)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (load),
    .value (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign busy     = conv_busy;
  assign bcd_wide = (WIDE_D*BCD_W)'(conv_bcd);

  always_comb begin
    conv_ovf = 1'b0;
    for (int i = NUM_DIGITS; i < WIDE_D; i++)
      conv_ovf = conv_ovf | (|bcd_wide[i*BCD_W +: BCD_W]);
  end

  logic [NUM_DIGITS*BCD_W-1:0] disp_p1;
  logic                        ovf_p1;
  logic [REF_W-1:0]            ref_cnt_p1;
  logic [IDX_W-1:0]            idx_p1;
  logic [BLK_W-1:0]            blk_cnt_p1;
  logic                        phase_p1;

  // stage p1: display register, updated only by a completed conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_p1 <= '0;
      ovf_p1  <= 1'b0;
    end else if (conv_done) begin
      disp_p1 <= bcd_wide[NUM_DIGITS*BCD_W-1:0];
      ovf_p1  <= conv_ovf;
    end
  end

  assign overflow = ovf_p1;

  // stage p1: scan index and blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_p1 <= '0;
      idx_p1     <= '0;
      blk_cnt_p1 <= '0;
      phase_p1   <= 1'b0;
    end else begin
      if (ref_cnt_p1 == REF_W'(REFRESH_DIV - 1)) begin
        ref_cnt_p1 <= '0;
        idx_p1     <= (idx_p1 == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_p1 + 1'b1;
      end else begin
        ref_cnt_p1 <= ref_cnt_p1 + 1'b1;
      end
      // Holding the counter at zero too gives a full "on" window when blink starts.
      if (!blink_en) begin
        blk_cnt_p1 <= '0;
        phase_p1   <= 1'b0;
      end else if (blk_cnt_p1 == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt_p1 <= '0;
        phase_p1   <= ~phase_p1;
      end else begin
        blk_cnt_p1 <= blk_cnt_p1 + 1'b1;
      end
    end
  end

  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  higher_nz;
  logic [BCD_W-1:0]      cur_digit;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] anode_next;

  always_comb begin
    higher_nz = 1'b0;
    lz_blank  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_nz   = higher_nz | (|disp_p1[i*BCD_W +: BCD_W]);
      lz_blank[i] = blank_lz && (i != 0) && !higher_nz;
    end
    cur_digit = disp_p1[idx_p1*BCD_W +: BCD_W];
    if (ovf_p1)
      seg_next = SEG_DASH;
    else if (lz_blank[idx_p1])
      seg_next = SEG_BLANK;
    else
      seg_next = seg_encode(cur_digit);
    if (blink_en && phase_p1)
      anode_next = '1;
    else
      anode_next = ~(NUM_DIGITS'(1) << idx_p1);
  end

  logic [NUM_DIGITS-1:0] anode_p2;
  logic [6:0]            seg_p2;
  logic                  dp_p2;

  // stage p2: anode, segments and dp registered together so they switch on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_p2 <= '1;
      seg_p2   <= SEG_BLANK;
      dp_p2    <= 1'b1;
    end else begin
      anode_p2 <= anode_next;
      seg_p2   <= seg_next;
      dp_p2    <= ~dp_mask[idx_p1];
    end
  end

  assign anode = anode_p2;
  assign {A, B, C, D, E, F, G} = seg_p2;
  assign dp = dp_p2;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with 4 digits, 14-bit value,
// refresh every 4 cycles and a 64-cycle blink half-period.
module tb_seg7_scan_display;

  localparam int ND = 4;
  localparam int VW = 14;
  localparam int RD = 4;
  localparam int BD = 64;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b1111110;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] value;
  logic          load;
  logic          blank_lz;
  logic          blink_en;
  logic [ND-1:0] dp_mask;
  logic          busy;
  logic          overflow;
  logic [ND-1:0] anode;
  logic          A, B, C, D, E, F, G;
  logic          dp;

  int n_vec = 0;
  int n_bad = 0;

  logic [6:0]    cap_seg [ND];
  logic [ND-1:0] cap_seen;
  logic [6:0]    seg;

  assign seg = {A, B, C, D, E, F, G};

  seg7_scan_display #(
    .NUM_DIGITS  (ND),
    .VALUE_W     (VW),
    .REFRESH_DIV (RD),
    .BLINK_DIV   (BD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .overflow (overflow),
    .anode    (anode),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .E        (E),
    .F        (F),
    .G        (G),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Records the segment pattern seen while each digit is selected, over more than one scan period.
  task automatic capture();
    logic [ND-1:0] sel;
    cap_seen = '0;
    for (int d = 0; d < ND; d++) cap_seg[d] = 7'bxxxxxxx;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        sel = ~(ND'(1) << d);
        if (anode === sel) begin
          cap_seg[d]  = seg;
          cap_seen[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic pulse_load(input int v);
    @(negedge clk);
    value = VW'(v);
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (anode !== 4'b1111) begin n_bad++; $display("FAIL reset_anode: got %b expected 1111", anode); end
    n_vec++; if (seg !== SB) begin n_bad++; $display("FAIL reset_seg: got %b expected %b", seg, SB); end
    n_vec++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp: got %b expected 1", dp); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_release();
    blank_lz = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (anode !== 4'b1110) begin n_bad++; $display("FAIL release_anode: got %b expected 1110", anode); end
    n_vec++; if (seg !== S0) begin n_bad++; $display("FAIL release_seg: got %b expected %b", seg, S0); end
    capture();
    n_vec++; if (cap_seen !== 4'b1111) begin n_bad++; $display("FAIL release_scan: digits seen %b expected 1111", cap_seen); end
    n_vec++; if (cap_seg[0] !== S0) begin n_bad++; $display("FAIL release_d0: got %b expected %b", cap_seg[0], S0); end
    for (int d = 1; d < ND; d++) begin
      n_vec++; if (cap_seg[d] !== SB) begin n_bad++; $display("FAIL release_d%0d: got %b expected %b", d, cap_seg[d], SB); end
    end
  endtask

  task automatic test_convert_1234();
    int n;
    blank_lz = 1'b0;
    pulse_load(1234);
    wait_idle(n);
    n_vec++; if (n !== 14) begin n_bad++; $display("FAIL busy_len_1234: got %0d cycles expected 14", n); end
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_1234: got %b expected 0", overflow); end
    repeat (2) @(negedge clk);
    capture();
    n_vec++; if (cap_seg[3] !== S1) begin n_bad++; $display("FAIL d3_1234: got %b expected %b", cap_seg[3], S1); end
    n_vec++; if (cap_seg[2] !== S2) begin n_bad++; $display("FAIL d2_1234: got %b expected %b", cap_seg[2], S2); end
    n_vec++; if (cap_seg[1] !== S3) begin n_bad++; $display("FAIL d1_1234: got %b expected %b", cap_seg[1], S3); end
    n_vec++; if (cap_seg[0] !== S4) begin n_bad++; $display("FAIL d0_1234: got %b expected %b", cap_seg[0], S4); end
  endtask

  task automatic test_load_while_busy();
    int n;
    blank_lz = 1'b0;
    pulse_load(42);
    n = 0;
    while (busy && n < 100) begin
      if (n == 2) begin
        value = VW'(99);
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    load = 1'b0;
    n_vec++; if (n !== 14) begin n_bad++; $display("FAIL busy_len_42: got %0d cycles expected 14", n); end
    repeat (2) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_42: got %b expected 0", busy); end
    capture();
    n_vec++; if (cap_seg[3] !== S0) begin n_bad++; $display("FAIL d3_0042: got %b expected %b", cap_seg[3], S0); end
    n_vec++; if (cap_seg[2] !== S0) begin n_bad++; $display("FAIL d2_0042: got %b expected %b", cap_seg[2], S0); end
    n_vec++; if (cap_seg[1] !== S4) begin n_bad++; $display("FAIL d1_0042: got %b expected %b", cap_seg[1], S4); end
    n_vec++; if (cap_seg[0] !== S2) begin n_bad++; $display("FAIL d0_0042: got %b expected %b", cap_seg[0], S2); end
    blank_lz = 1'b1;
    repeat (2) @(negedge clk);
    capture();
    n_vec++; if (cap_seg[3] !== SB) begin n_bad++; $display("FAIL d3_42lz: got %b expected %b", cap_seg[3], SB); end
    n_vec++; if (cap_seg[2] !== SB) begin n_bad++; $display("FAIL d2_42lz: got %b expected %b", cap_seg[2], SB); end
    n_vec++; if (cap_seg[1] !== S4) begin n_bad++; $display("FAIL d1_42lz: got %b expected %b", cap_seg[1], S4); end
    n_vec++; if (cap_seg[0] !== S2) begin n_bad++; $display("FAIL d0_42lz: got %b expected %b", cap_seg[0], S2); end
  endtask

  task automatic test_overflow();
    int n;
    blank_lz = 1'b0;
    pulse_load(10000);
    wait_idle(n);
    n_vec++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_10000: got %b expected 1 (busy cycles %0d)", overflow, n); end
    repeat (2) @(negedge clk);
    capture();
    for (int d = 0; d < ND; d++) begin
      n_vec++; if (cap_seg[d] !== SD) begin n_bad++; $display("FAIL dash_d%0d: got %b expected %b", d, cap_seg[d], SD); end
    end
    pulse_load(9999);
    wait_idle(n);
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_9999: got %b expected 0 (busy cycles %0d)", overflow, n); end
    repeat (2) @(negedge clk);
    capture();
    for (int d = 0; d < ND; d++) begin
      n_vec++; if (cap_seg[d] !== S9) begin n_bad++; $display("FAIL nine_d%0d: got %b expected %b", d, cap_seg[d], S9); end
    end
  endtask

  task automatic test_reset_abort();
    blank_lz = 1'b1;
    pulse_load(5678);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_vec++; if (anode !== 4'b1111) begin n_bad++; $display("FAIL abort_anode: got %b expected 1111", anode); end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy_late: got %b expected 0", busy); end
    n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL abort_ovf: got %b expected 0", overflow); end
    capture();
    n_vec++; if (cap_seg[0] !== S0) begin n_bad++; $display("FAIL abort_d0: got %b expected %b", cap_seg[0], S0); end
    for (int d = 1; d < ND; d++) begin
      n_vec++; if (cap_seg[d] !== SB) begin n_bad++; $display("FAIL abort_d%0d: got %b expected %b", d, cap_seg[d], SB); end
    end
  endtask

  task automatic test_blink_dp();
    int first_off = 0;
    int n_off     = 0;
    int dp_bad    = 0;
    int dp_seen   = 0;
    blank_lz = 1'b0;
    dp_mask  = 4'b0010;
    blink_en = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      @(negedge clk);
      if (anode === 4'b1111) begin
        n_off++;
        if (first_off == 0) first_off = k;
      end else begin
        if ((dp === 1'b0) != (anode === 4'b1101)) dp_bad++;
        if (dp === 1'b0) dp_seen++;
      end
    end
    blink_en = 1'b0;
    n_vec++; if (first_off !== 65) begin n_bad++; $display("FAIL blink_first_off: got cycle %0d expected 65", first_off); end
    n_vec++; if (n_off !== 128) begin n_bad++; $display("FAIL blink_off_cycles: got %0d expected 128", n_off); end
    n_vec++; if (dp_bad !== 0) begin n_bad++; $display("FAIL dp_digit1: got %0d wrong cycles expected 0", dp_bad); end
    n_vec++; if (dp_seen == 0) begin n_bad++; $display("FAIL dp_lit: got %0d lit cycles expected >0", dp_seen); end
    repeat (2) @(negedge clk);
    n_vec++; if (anode === 4'b1111) begin n_bad++; $display("FAIL blink_off_restore: got %b expected one-hot low", anode); end
  endtask

  initial begin
    rst      = 1'b1;
    value    = '0;
    load     = 1'b0;
    blank_lz = 1'b1;
    blink_en = 1'b0;
    dp_mask  = '0;
    test_reset();
    test_release();
    test_convert_1234();
    test_load_while_busy();
    test_overflow();
    test_reset_abort();
    test_blink_dp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
SEG7_SCAN_DISPLAY -- requirements
Module: seg7_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of multiplexed 7-segment digits (1..8).
REQ-002 Parameter VALUE_W, default 27, width of the binary input value.
REQ-003 Parameter REFRESH_DIV, default 100000, clk cycles each digit stays selected (minimum 2).
REQ-004 Parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (minimum 2).
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-006 value  in  VALUE_W  unsigned binary number to display.
REQ-007 load  in  1  single-cycle strobe that starts a conversion of value.
REQ-008 blank_lz  in  1  1 = blank leading zeros.
REQ-009 blink_en  in  1  1 = blink the whole display.
REQ-010 dp_mask  in  NUM_DIGITS  per-digit decimal point enable, bit i = digit i.
REQ-011 busy  out  1  conversion in progress.
REQ-012 overflow  out  1  displayed value exceeds 10^NUM_DIGITS-1.
REQ-013 anode  out  NUM_DIGITS  active-low digit select, digit 0 = least significant.
REQ-014 A, B, C, D, E, F, G  out  1 each  active-low segment drives.
REQ-015 dp  out  1  active-low decimal point.

Function
REQ-016 A load sampled while busy=0 SHALL latch value and start a sequential shift-add-3 binary-to-BCD conversion taking exactly VALUE_W cycles.
REQ-017 Load accepted in cycle n: busy SHALL be 1 in cycles n+1..n+VALUE_W, and the display digit register SHALL update atomically at the end of cycle n+VALUE_W.
REQ-018 A load while busy=1 SHALL be ignored, with no effect on the running conversion.
REQ-019 The display register SHALL hold its last result until the next conversion completes; a partial result SHALL never be shown.
REQ-020 If the conversion result needs more than NUM_DIGITS BCD digits, overflow SHALL be set with the update and every digit SHALL show a dash (G only); otherwise overflow SHALL be cleared.
REQ-021 A refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, the digit index SHALL advance by one modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
REQ-022 anode SHALL be one-hot low at the current index, registered, and SHALL change in the same cycle as seg/dp (no ghosting cycle with mismatched data).
REQ-023 Segment encoding: 0..9 SHALL use standard patterns; blank SHALL be all segments 1.
REQ-024 With blank_lz=1, digits above the most significant nonzero digit SHALL be blank; digit 0 SHALL always be shown; dp still follows dp_mask.
REQ-025 dp SHALL be 0 when dp_mask[index]=1.
REQ-026 A blink counter SHALL toggle a phase every BLINK_DIV cycles; while blink_en=1 and phase=1, anode SHALL be all 1; the scan SHALL continue underneath.
REQ-027 When blink_en=0 the phase SHALL be held at 0 so that enabling blink starts visibly on.

Reset
REQ-028 While rst=1: anode all 1, A..G = 1, dp=1, busy=0, overflow=0, display register = 0, digit index = 0, and the refresh and blink counters and phase = 0.
REQ-029 rst during a conversion SHALL abort it; no result is written.
REQ-030 In the first cycle after rst falls, anode[0]=0 showing "0".

Structure
REQ-031 Package seg7_pkg SHALL hold the segment pattern constants (digits 0-9, SEG_BLANK, SEG_DASH) and the BCD digit width constant.
REQ-032 Conversion SHALL live in sub-module bin2bcd_seq (start/busy/done handshake); scanning, blanking and blink SHALL stay in the top.

Verification (NUM_DIGITS=4, VALUE_W=14, REFRESH_DIV=4, BLINK_DIV=64)
REQ-033 Reset, then release with blank_lz=1 -> anode cycles 1110 only lit / others 1111-equivalent blank segments; digit 0 shows "0" (ABCDEFG=0000001).
REQ-034 load value=1234 -> busy high exactly 14 cycles; digits 3..0 then show 1,2,3,4 (digit 3 = 1001111); overflow=0.
REQ-035 load 42, load 99 three cycles later -> 99 ignored; display "0042" / " 42" with blank_lz=0/1.
REQ-036 load 10000 -> overflow=1; all four digits show 1111110; then load 9999 -> overflow=0, "9999".
REQ-037 rst asserted at cycle 5 of a conversion of 5678 -> busy=0 next cycle; display "0"; no later update.
REQ-038 blink_en=1, dp_mask=0010 -> anode all 1 for 64-cycle windows alternating with scanning; dp=0 only while digit 1 is selected.
